// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_ctrl_pkg                                                         |
// | Shared types and defaults for the FIR coefficient-bank controller.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fir_ctrl_pkg;

    localparam int FIR_NUM_COEFFS  = 64;
    localparam int FIR_COEFF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ARMED  = 2'd2
    } ctrl_state_e;

    typedef logic [FIR_NUM_COEFFS-1:0][FIR_COEFF_WIDTH-1:0] coeff_bank_t;

endpackage
`default_nettype wire

// File: rtl/coeff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coeff_bank                                                           |
// | Tap register array with random-access write and full parallel load.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module coeff_bank
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_COEFFS  = FIR_NUM_COEFFS,
    parameter int COEFF_WIDTH = FIR_COEFF_WIDTH,
    parameter int ADDR_WIDTH  = $clog2(NUM_COEFFS),
    parameter int RESET_TAP0  = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_wr_en,
    input  logic [ADDR_WIDTH-1:0]                  i_wr_addr,
    input  logic [COEFF_WIDTH-1:0]                 i_wr_data,
    input  logic                                   i_load_en,
    input  logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] i_load_data,
    output logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] o_rd_data
);

    for (genvar g = 0; g < NUM_COEFFS; g++) begin : g_tap
        localparam logic [COEFF_WIDTH-1:0] c_reset_val =
            (g == 0) ? COEFF_WIDTH'(RESET_TAP0) : '0;

        logic [COEFF_WIDTH-1:0] r_tap;

        // Out-of-range addresses never match any tap index, so they are dropped.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_tap <= c_reset_val;
            end else if (i_load_en) begin
                r_tap <= i_load_data[g];
            end else if (i_wr_en && (i_wr_addr == ADDR_WIDTH'(g))) begin
                r_tap <= i_wr_data;
            end
        end

        assign o_rd_data[g] = r_tap;
    end

endmodule
`default_nettype wire

// File: rtl/fir_coeff_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fir_coeff_ctrl                                                       |
// | Shadow/active coefficient banks with sample-aligned swap for the FIR.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fir_coeff_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int NUM_COEFFS    = FIR_NUM_COEFFS,
    parameter int COEFF_WIDTH   = FIR_COEFF_WIDTH,
    parameter int ADDR_WIDTH    = $clog2(NUM_COEFFS),
    parameter int RESET_TAP0    = 1,
    parameter int FLUSH_ON_SWAP = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic [ADDR_WIDTH-1:0]                  wr_addr,
    input  logic [COEFF_WIDTH-1:0]                 wr_data,
    input  logic                                   load_start,
    input  logic [COEFF_WIDTH-1:0]                 stream_data,
    input  logic                                   stream_valid,
    output logic                                   stream_ready,
    input  logic                                   commit,
    input  logic                                   sample_strobe,
    output logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] coeffs_out,
    output logic                                   busy,
    output logic                                   swap_done,
    output logic                                   fir_flush
);

    localparam logic [ADDR_WIDTH-1:0] c_last_tap = ADDR_WIDTH'(NUM_COEFFS - 1);

    ctrl_state_e                            r_state;
    ctrl_state_e                            w_next_state;
    logic [ADDR_WIDTH-1:0]                  r_count;
    logic                                   r_swap_done;
    logic                                   w_host_we;
    logic                                   w_stream_we;
    logic                                   w_swap;
    logic                                   w_shadow_we;
    logic [ADDR_WIDTH-1:0]                  w_shadow_addr;
    logic [COEFF_WIDTH-1:0]                 w_shadow_data;
    logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] w_shadow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (load_start) begin
                    w_next_state = STREAM;
                end else if (commit) begin
                    w_next_state = ARMED;
                end
            end
            STREAM: begin
                if (stream_valid && (r_count == c_last_tap)) begin
                    w_next_state = IDLE;
                end
            end
            ARMED: begin
                if (sample_strobe) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        stream_ready = (r_state == STREAM);
        busy         = (r_state != IDLE);
        w_host_we    = (r_state == IDLE) && wr_en;
        w_stream_we  = (r_state == STREAM) && stream_valid;
        w_swap       = (r_state == ARMED) && sample_strobe;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if ((r_state == IDLE) && load_start) begin
            r_count <= '0;
        end else if (w_stream_we) begin
            r_count <= r_count + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_swap_done <= 1'b0;
        end else begin
            r_swap_done <= w_swap;
        end
    end

    // Stream and host writes are mutually exclusive by state, so a plain mux suffices.
    assign w_shadow_we   = w_host_we || w_stream_we;
    assign w_shadow_addr = w_stream_we ? r_count : wr_addr;
    assign w_shadow_data = w_stream_we ? stream_data : wr_data;

    coeff_bank #(
        .NUM_COEFFS  (NUM_COEFFS),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .RESET_TAP0  (RESET_TAP0)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_shadow_we),
        .i_wr_addr   (w_shadow_addr),
        .i_wr_data   (w_shadow_data),
        .i_load_en   (1'b0),
        .i_load_data ('0),
        .o_rd_data   (w_shadow_q)
    );

    coeff_bank #(
        .NUM_COEFFS  (NUM_COEFFS),
        .COEFF_WIDTH (COEFF_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .RESET_TAP0  (RESET_TAP0)
    ) u_active (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (1'b0),
        .i_wr_addr   ('0),
        .i_wr_data   ('0),
        .i_load_en   (w_swap),
        .i_load_data (w_shadow_q),
        .o_rd_data   (coeffs_out)
    );

    assign swap_done = r_swap_done;

    if (FLUSH_ON_SWAP != 0) begin : g_flush
        assign fir_flush = r_swap_done;
    end else begin : g_no_flush
        assign fir_flush = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fir_coeff_ctrl                                                    |
// | Directed bench for fir_coeff_ctrl, with and without flush-on-swap.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fir_coeff_ctrl;
    import fir_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        load_start;
    logic [15:0] stream_data;
    logic        stream_valid;
    logic        commit;
    logic        sample_strobe;

    logic        stream_ready, busy, swap_done, fir_flush;
    coeff_bank_t coeffs_out;
    logic        stream_ready_f, busy_f, swap_done_f, fir_flush_f;
    coeff_bank_t coeffs_out_f;

    coeff_bank_t exp_bank;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    fir_coeff_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_start(load_start), .stream_data(stream_data), .stream_valid(stream_valid),
        .stream_ready(stream_ready), .commit(commit), .sample_strobe(sample_strobe),
        .coeffs_out(coeffs_out), .busy(busy), .swap_done(swap_done), .fir_flush(fir_flush)
    );

    fir_coeff_ctrl #(.FLUSH_ON_SWAP(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_start(load_start), .stream_data(stream_data), .stream_valid(stream_valid),
        .stream_ready(stream_ready_f), .commit(commit), .sample_strobe(sample_strobe),
        .coeffs_out(coeffs_out_f), .busy(busy_f), .swap_done(swap_done_f), .fir_flush(fir_flush_f)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bank(input string tag, input coeff_bank_t obs, input coeff_bank_t exp);
        int bad;
        bad = -1;
        for (int i = NUM_TAPS() - 1; i >= 0; i--) begin
            if (obs[i] !== exp[i]) bad = i;
        end
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: tap %0d observed %h expected %h", tag, bad,
                   obs[(bad < 0) ? 0 : bad], exp[(bad < 0) ? 0 : bad]);
        end
    endtask

    function automatic int NUM_TAPS();
        return FIR_NUM_COEFFS;
    endfunction

    function automatic coeff_bank_t reset_bank();
        coeff_bank_t b;
        b    = '0;
        b[0] = 16'h0001;
        return b;
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; load_start = 1'b0;
        stream_data = '0; stream_valid = 1'b0; commit = 1'b0; sample_strobe = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state and idle strobes
        exp_bank = reset_bank();
        chk_bank("reset_coeffs", coeffs_out, exp_bank);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(stream_ready), 32'd0);
        chk("reset_swap_done", 32'(swap_done), 32'd0);
        chk("reset_flush_f", 32'(fir_flush_f), 32'd0);
        sample_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_strobe_no_swap", 32'(swap_done), 32'd0);
        end
        sample_strobe = 1'b0;
        chk_bank("idle_strobe_coeffs", coeffs_out, exp_bank);

        // Random-access writes, commit, delayed strobe
        wr_en = 1'b1; wr_addr = 6'd3;  wr_data = 16'h7FFF; tick();
        wr_addr = 6'd63; wr_data = 16'h8000; tick();
        wr_en = 1'b0;
        chk_bank("write_no_active_change", coeffs_out, exp_bank);
        commit = 1'b1; tick(); commit = 1'b0;
        chk("armed_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_bank("armed_wait_coeffs", coeffs_out, exp_bank);
            chk("armed_wait_swap_done", 32'(swap_done), 32'd0);
        end
        sample_strobe = 1'b1; tick(); sample_strobe = 1'b0;
        exp_bank[3]  = 16'h7FFF;
        exp_bank[63] = 16'h8000;
        chk_bank("swap1_coeffs", coeffs_out, exp_bank);
        chk("swap1_tap63_signed", 32'($signed(coeffs_out[63])), -32'sd32768);
        chk("swap1_swap_done", 32'(swap_done), 32'd1);
        chk("swap1_busy", 32'(busy), 32'd0);
        chk("swap1_flush_off", 32'(fir_flush), 32'd0);
        chk("swap1_flush_on", 32'(fir_flush_f), 32'd1);
        chk("swap1_done_f", 32'(swap_done_f), 32'd1);
        chk_bank("swap1_coeffs_f", coeffs_out_f, exp_bank);
        tick();
        chk("swap1_done_pulse_end", 32'(swap_done), 32'd0);
        chk("swap1_flush_pulse_end", 32'(fir_flush_f), 32'd0);

        // Stream 64 words with gaps; host commands in gaps are ignored
        load_start = 1'b1; tick(); load_start = 1'b0;
        chk("stream_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 64; i++) begin
            stream_valid = 1'b1; stream_data = 16'(i + 1);
            wr_en = 1'b0; commit = 1'b0; load_start = 1'b0;
            chk("stream_ready_valid", 32'(stream_ready), 32'd1);
            tick();
            if (i < 63) begin
                stream_valid = 1'b0; stream_data = 16'hDEAD;
                wr_en = 1'b1; wr_addr = 6'd10; wr_data = 16'h1234;
                commit = 1'b1; load_start = 1'b1;
                chk("stream_ready_gap", 32'(stream_ready), 32'd1);
                tick();
            end
        end
        stream_valid = 1'b0; wr_en = 1'b0; commit = 1'b0; load_start = 1'b0;
        chk("stream_end_ready", 32'(stream_ready), 32'd0);
        chk("stream_end_busy", 32'(busy), 32'd0);
        chk_bank("stream_no_active_change", coeffs_out, exp_bank);

        // Commit with strobe already high: first strobe after ARMED swaps
        commit = 1'b1; sample_strobe = 1'b1; tick(); commit = 1'b0;
        chk("commit_strobe_busy", 32'(busy), 32'd1);
        chk("commit_strobe_no_swap", 32'(swap_done), 32'd0);
        chk_bank("commit_strobe_coeffs", coeffs_out, exp_bank);
        tick(); sample_strobe = 1'b0;
        for (int i = 0; i < 64; i++) exp_bank[i] = 16'(i + 1);
        chk_bank("swap2_coeffs", coeffs_out, exp_bank);
        chk("swap2_swap_done", 32'(swap_done), 32'd1);
        tick();

        // Commands while ARMED are ignored
        commit = 1'b1; tick();
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 16'h5555; load_start = 1'b1;
        tick(); tick();
        wr_en = 1'b0; load_start = 1'b0; commit = 1'b0;
        chk("armed_ignore_ready", 32'(stream_ready), 32'd0);
        chk("armed_ignore_busy", 32'(busy), 32'd1);
        sample_strobe = 1'b1; tick(); sample_strobe = 1'b0;
        chk_bank("armed_ignore_coeffs", coeffs_out, exp_bank);
        chk("armed_ignore_tap5", 32'(coeffs_out[5]), 32'h0006);
        tick();
        chk("armed_ignore_no_rearm", 32'(busy), 32'd0);

        // wr_en together with commit in IDLE is still performed
        wr_en = 1'b1; wr_addr = 6'd7; wr_data = 16'h0777; commit = 1'b1; tick();
        wr_en = 1'b0; commit = 1'b0;
        sample_strobe = 1'b1; tick(); sample_strobe = 1'b0;
        exp_bank[7] = 16'h0777;
        chk_bank("wr_with_commit", coeffs_out, exp_bank);
        tick();

        // load_start and commit together: stream wins, commit dropped
        load_start = 1'b1; commit = 1'b1; tick(); load_start = 1'b0; commit = 1'b0;
        chk("ls_commit_ready", 32'(stream_ready), 32'd1);
        stream_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            stream_data = 16'(16'h0100 + i);
            tick();
        end
        stream_valid = 1'b0;
        chk("ls_commit_end_ready", 32'(stream_ready), 32'd0);
        chk("ls_commit_end_busy", 32'(busy), 32'd0);
        sample_strobe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ls_commit_no_swap", 32'(swap_done), 32'd0);
        end
        sample_strobe = 1'b0;
        chk_bank("ls_commit_coeffs", coeffs_out, exp_bank);
        commit = 1'b1; tick(); commit = 1'b0;
        sample_strobe = 1'b1; tick(); sample_strobe = 1'b0;
        for (int i = 0; i < 64; i++) exp_bank[i] = 16'(16'h0100 + i);
        chk_bank("swap3_coeffs", coeffs_out, exp_bank);
        tick();

        // Reset after 20 stream words
        load_start = 1'b1; tick(); load_start = 1'b0;
        stream_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            stream_data = 16'(16'h0200 + i);
            tick();
        end
        stream_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        exp_bank = reset_bank();
        chk_bank("rst_stream_coeffs", coeffs_out, exp_bank);
        chk("rst_stream_busy", 32'(busy), 32'd0);
        chk("rst_stream_ready", 32'(stream_ready), 32'd0);
        chk("rst_stream_swap_done", 32'(swap_done), 32'd0);
        commit = 1'b1; tick(); commit = 1'b0;
        sample_strobe = 1'b1; tick(); sample_strobe = 1'b0;
        chk_bank("rst_stream_shadow", coeffs_out, exp_bank);
        chk("rst_stream_swap_after", 32'(swap_done), 32'd1);
        tick();

        // Reset while ARMED, with a strobe on the reset edge
        wr_en = 1'b1; wr_addr = 6'd2; wr_data = 16'h2222; tick(); wr_en = 1'b0;
        commit = 1'b1; tick(); commit = 1'b0;
        chk("pre_rst_armed_busy", 32'(busy), 32'd1);
        rst = 1'b1; sample_strobe = 1'b1; tick(); rst = 1'b0;
        chk_bank("rst_armed_coeffs", coeffs_out, exp_bank);
        chk("rst_armed_busy", 32'(busy), 32'd0);
        chk("rst_armed_swap_done", 32'(swap_done), 32'd0);
        chk("rst_armed_flush_f", 32'(fir_flush_f), 32'd0);
        tick();
        chk("rst_armed_no_late_swap", 32'(swap_done), 32'd0);
        sample_strobe = 1'b0;
        commit = 1'b1; tick(); commit = 1'b0;
        sample_strobe = 1'b1; tick(); sample_strobe = 1'b0;
        chk_bank("rst_armed_shadow", coeffs_out, exp_bank);
        chk("rst_armed_swap_after", 32'(swap_done), 32'd1);
        chk("rst_armed_flush_after", 32'(fir_flush_f), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
